pkt_ctrl_mc: RTL and testbench

Multi-channel packet transfer controller for the tcpdump capture path.
- Arbitrates round-robin among NUM_CH capture-channel requests.
- Runs a read phase, then a write phase, for the granted channel.
- Each phase is supervised by a timeout; abandoned handshakes cannot hang the datapath.
- Keeps a completed-packet counter and a sticky error flag for the host-side status registers.

---
 rtl/pkt_ctrl_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/pkt_ctrl_mc.sv | 172 +++++++++++++++++
 tb/tb_pkt_ctrl_mc.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pkt_ctrl_pkg
// Shared types for the multi-channel packet transfer controller.
//   pkt_state_e : controller FSM state encoding (3 bits)
// -----------------------------------------------------------------------------
package pkt_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } pkt_state_e;

endpackage : pkt_ctrl_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Scans req_i starting at
// (last_id_i + 1) mod NUM_CH, wrapping, and returns the first set index.
// The owner keeps the last_id register.
//   req_i     : per-channel request vector
//   last_id_i : channel served most recently
//   valid_i   : arbitration allowed this cycle
//   gnt_id_o  : selected channel index (0 when nothing is requesting)
//   any_req_o : valid_i && at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [ID_W-1:0]   last_id_i,
   input  logic              valid_i,
   output logic [ID_W-1:0]   gnt_id_o,
   output logic              any_req_o
);

   logic found;
   int   idx;

   always_comb begin
      gnt_id_o = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         // last_id + k never exceeds 2*NUM_CH-1, so one conditional
         // subtract replaces a modulo.
         idx = int'(last_id_i) + k;
         if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
         end
         if (!found && req_i[idx]) begin
            gnt_id_o = ID_W'(idx);
            found    = 1'b1;
         end
      end
   end

   assign any_req_o = valid_i && (|req_i);

endmodule : rr_arbiter

// File: rtl/pkt_ctrl_mc.sv
// -----------------------------------------------------------------------------
// pkt_ctrl_mc
// Multi-channel packet transfer controller. Grants one requesting channel
// round-robin, runs its read phase then its write phase, each phase under an
// optional timeout, and reports completion (ack) or timeout (abort).
//   clk, reset     : clock, asynchronous active-low reset
//   enable         : permits new grants (in-flight transfer always completes)
//   req[NUM_CH]    : per-channel request, level
//   rd_rdy, wr_rdy : read/write engine done with the current packet
//   clr_cnt        : synchronous clear of pkt_cnt and timeout_err
//   rd_ctrl        : read engine start/hold (high throughout RD)
//   wr_ctrl        : write engine start/hold (high throughout WR)
//   grant_id       : index of the channel being served
//   busy           : controller not in IDLE
//   ack, abort     : one-cycle one-hot completion / timeout pulses
//   timeout_err    : sticky timeout flag
//   pkt_cnt        : saturating completed-packet count
//   dbg_state      : current FSM state, for observation
//
// Handshake: rd_ctrl (wr_ctrl) acts as a valid held high for the whole phase;
// the engine answers with a single-cycle rd_rdy (wr_rdy) acting as ready, and
// the phase closes on the first clock edge that samples ready high while the
// matching ctrl is high. A ready seen during the other phase is ignored.
// -----------------------------------------------------------------------------
module pkt_ctrl_mc
   import pkt_ctrl_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [NUM_CH-1:0] req,
   input  logic              rd_rdy,
   input  logic              wr_rdy,
   input  logic              clr_cnt,
   output logic              rd_ctrl,
   output logic              wr_ctrl,
   output logic [ID_W-1:0]   grant_id,
   output logic              busy,
   output logic [NUM_CH-1:0] ack,
   output logic [NUM_CH-1:0] abort,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  pkt_cnt,
   output pkt_state_e        dbg_state
);

   // The timer only ever counts up to TIMEOUT_CYC-1.
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST =
      (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : '0;
   localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_CH - 1);

   pkt_state_e        state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [ID_W-1:0]   arb_id;
   logic              arb_any;
   logic              tmr_expired;
   logic [NUM_CH-1:0] grant_oh;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .ID_W   (ID_W)
   ) u_arb (
      .req_i     (req),
      .last_id_i (last_q),
      .valid_i   (enable && (state_q == IDLE)),
      .gnt_id_o  (arb_id),
      .any_req_o (arb_any)
   );

   assign tmr_expired = (TIMEOUT_CYC != 0) && (timer_q == TMR_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
         timer_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (arb_any) begin
               grant_d = arb_id;
               timer_d = '0;
               state_d = RD;
            end
         end
         RD: begin
            // Ready is checked first so it wins over a coincident expiry.
            if (rd_rdy) begin
               timer_d = '0;
               state_d = WR;
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               state_d = ERR;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         WR: begin
            if (wr_rdy) begin
               cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
               state_d = DONE;
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               state_d = ERR;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         DONE: begin
            last_d  = grant_q;
            state_d = IDLE;
         end
         ERR: begin
            // A timed-out channel drops to lowest priority next round.
            last_d  = grant_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Host clear overrides any same-cycle increment or error set.
      if (clr_cnt) begin
         cnt_d = '0;
         err_d = 1'b0;
      end
   end

   assign grant_oh    = NUM_CH'(1) << grant_q;

   assign rd_ctrl     = (state_q == RD);
   assign wr_ctrl     = (state_q == WR);
   assign busy        = (state_q != IDLE);
   assign ack         = (state_q == DONE) ? grant_oh : '0;
   assign abort       = (state_q == ERR)  ? grant_oh : '0;
   assign grant_id    = grant_q;
   assign timeout_err = err_q;
   assign pkt_cnt     = cnt_q;
   assign dbg_state   = state_q;

endmodule : pkt_ctrl_mc

// File: tb/tb_pkt_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_pkt_ctrl_mc
// Directed plus randomized bench for pkt_ctrl_mc (NUM_CH=4, CNT_W=2,
// TIMEOUT_CYC=8) and a second single-channel instance with the timeout off.
// Expected values come from a small transaction-level model: round-robin pick
// from the last served channel, saturating packet count, sticky error flag.
// -----------------------------------------------------------------------------
module tb_pkt_ctrl_mc;
   import pkt_ctrl_pkg::*;

   localparam int NCH  = 4;
   localparam int CW   = 2;
   localparam int TO   = 8;
   localparam int CMAX = (1 << CW) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- main DUT ----------------
   logic           enable, rd_rdy, wr_rdy, clr_cnt;
   logic [NCH-1:0] req;
   logic           rd_ctrl, wr_ctrl, busy, timeout_err;
   logic [1:0]     grant_id;
   logic [NCH-1:0] ack, abort;
   logic [CW-1:0]  pkt_cnt;
   pkt_state_e     dbg_state;

   pkt_ctrl_mc #(
      .NUM_CH      (NCH),
      .CNT_W       (CW),
      .TIMEOUT_CYC (TO)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .req         (req),
      .rd_rdy      (rd_rdy),
      .wr_rdy      (wr_rdy),
      .clr_cnt     (clr_cnt),
      .rd_ctrl     (rd_ctrl),
      .wr_ctrl     (wr_ctrl),
      .grant_id    (grant_id),
      .busy        (busy),
      .ack         (ack),
      .abort       (abort),
      .timeout_err (timeout_err),
      .pkt_cnt     (pkt_cnt),
      .dbg_state   (dbg_state)
   );

   // ---------------- single-channel DUT, timeout disabled ----------------
   logic        enable1, rd_rdy1, wr_rdy1, clr1;
   logic [0:0]  req1, grant_id1, ack1, abort1;
   logic        rd_ctrl1, wr_ctrl1, busy1, timeout_err1;
   logic [15:0] pkt_cnt1;
   pkt_state_e  dbg_state1;

   pkt_ctrl_mc #(
      .NUM_CH      (1),
      .CNT_W       (16),
      .TIMEOUT_CYC (0)
   ) u_one (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable1),
      .req         (req1),
      .rd_rdy      (rd_rdy1),
      .wr_rdy      (wr_rdy1),
      .clr_cnt     (clr1),
      .rd_ctrl     (rd_ctrl1),
      .wr_ctrl     (wr_ctrl1),
      .grant_id    (grant_id1),
      .busy        (busy1),
      .ack         (ack1),
      .abort       (abort1),
      .timeout_err (timeout_err1),
      .pkt_cnt     (pkt_cnt1),
      .dbg_state   (dbg_state1)
   );

   // ---------------- scoreboard / model state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int m_last;
   int m_cnt;
   bit m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_pick(input logic [NCH-1:0] rq);
      for (int k = 1; k <= NCH; k++) begin
         int i;
         i = (m_last + k) % NCH;
         if (rq[i]) return i;
      end
      return 0;
   endfunction

   task automatic clear_counters();
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
      check("clr_pkt_cnt", pkt_cnt, 0);
      check("clr_timeout_err", timeout_err, 0);
   endtask

   // One phase (read or write). The engine answers wait_c cycles into the
   // phase; if that is past the timeout window the phase expires instead.
   task automatic run_phase(input bit is_wr, input int wait_c, input bit clr_last, output bit to);
      to = 1'b0;
      for (int c = 0; c < TO; c++) begin
         bit fin;
         fin = (c == wait_c) || (c == TO - 1);
         if (is_wr) begin
            rd_rdy = 1'($urandom_range(0, 1));
            wr_rdy = (c == wait_c);
         end else begin
            wr_rdy = 1'($urandom_range(0, 1));
            rd_rdy = (c == wait_c);
         end
         clr_cnt = fin && clr_last && (is_wr || (c != wait_c));
         if (fin && (is_wr || (c != wait_c))) req = '0;
         step();
         clr_cnt = 1'b0;
         rd_rdy  = 1'b0;
         wr_rdy  = 1'b0;
         if (c == wait_c) return;
         if (c == TO - 1) begin
            to = 1'b1;
            return;
         end
         check(is_wr ? "wr_ctrl_hold" : "rd_ctrl_hold", is_wr ? wr_ctrl : rd_ctrl, 1);
      end
   endtask

   task automatic do_txn(input logic [NCH-1:0] rq, input int rd_wait, input int wr_wait,
                         input bit clr_last, input bit drop_en);
      int g;
      bit to;
      g = model_pick(rq);
      req = rq;
      step();
      check("grant_rd_ctrl", rd_ctrl, 1);
      check("grant_id", grant_id, g);
      check("grant_busy", busy, 1);
      req = NCH'($urandom_range(0, 15));
      if (drop_en) enable = 1'b0;
      run_phase(1'b0, rd_wait, clr_last, to);
      if (!to) begin
         check("wr_ctrl_entry", wr_ctrl, 1);
         check("rd_ctrl_off", rd_ctrl, 0);
         run_phase(1'b1, wr_wait, clr_last, to);
      end
      if (to) begin
         m_err = 1'b1;
         if (clr_last) begin
            m_err = 1'b0;
            m_cnt = 0;
         end
         check("abort_pulse", abort, 32'(1) << g);
         check("abort_no_ack", ack, 0);
         check("abort_ctrl_off", {rd_ctrl, wr_ctrl}, 0);
      end else begin
         if (m_cnt < CMAX) m_cnt++;
         if (clr_last) begin
            m_err = 1'b0;
            m_cnt = 0;
         end
         check("ack_pulse", ack, 32'(1) << g);
         check("ack_no_abort", abort, 0);
      end
      check("pkt_cnt", pkt_cnt, m_cnt);
      check("timeout_err", timeout_err, m_err);
      m_last = g;
      step();
      check("idle_busy", busy, 0);
      check("idle_pulses", {ack, abort}, 0);
      if (drop_en) begin
         req = '1;
         repeat (3) step();
         check("no_grant_when_disabled", busy, 0);
         req = '0;
         enable = 1'b1;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      bit to;
      reset   = 1'b0;
      enable  = 1'b0;
      req     = '0;
      rd_rdy  = 1'b0;
      wr_rdy  = 1'b0;
      clr_cnt = 1'b0;
      enable1 = 1'b0;
      req1    = '0;
      rd_rdy1 = 1'b0;
      wr_rdy1 = 1'b0;
      clr1    = 1'b0;
      m_last  = NCH - 1;
      m_cnt   = 0;
      m_err   = 1'b0;

      // Reset values
      repeat (2) step();
      check("rst_ctrl", {rd_ctrl, wr_ctrl, busy}, 0);
      check("rst_pulses", {ack, abort}, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_cnt_err", {pkt_cnt, timeout_err}, 0);
      check("rst_state", dbg_state, IDLE);
      reset  = 1'b1;
      enable = 1'b1;
      step();

      // Fairness: all requesting, immediate engine answers -> 0,1,2,3,0
      for (int i = 0; i < 5; i++) do_txn(4'b1111, 0, 0, 1'b0, 1'b0);

      // Single request: rd_rdy at cycle 3, wr_rdy at cycle 5, ack at 6
      clear_counters();
      do_txn(4'b0100, 2, 1, 1'b0, 1'b0);

      // Timeout in RD, then faulty channel loses priority
      do_txn(4'b0010, 20, 0, 1'b0, 1'b0);
      do_txn(4'b0110, 0, 0, 1'b0, 1'b0);

      // Ready and expiry in the same cycle: ready wins (RD then WR)
      clear_counters();
      do_txn(4'b0001, TO - 1, TO - 1, 1'b0, 1'b0);

      // Timeout in WR
      do_txn(4'b1000, 1, 30, 1'b0, 1'b0);

      // Saturation, then clear coincident with completion, then with timeout
      clear_counters();
      for (int i = 0; i < 5; i++) do_txn(4'b0001, 0, 0, 1'b0, 1'b0);
      do_txn(4'b0011, 1, 1, 1'b1, 1'b0);
      do_txn(4'b0100, 1, 1, 1'b0, 1'b0);
      do_txn(4'b0100, 20, 0, 1'b1, 1'b0);

      // Enable dropped mid-transfer: it finishes, no further grants
      do_txn(4'b1010, 2, 2, 1'b0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         do_txn(NCH'($urandom_range(1, 15)), $urandom_range(0, 9), $urandom_range(0, 9),
                1'($urandom_range(0, 7) == 0), 1'b0);
      end

      // Reset asserted mid-WR
      req = 4'b0100;
      step();
      req = '0;
      run_phase(1'b0, 0, 1'b0, to);
      check("pre_reset_wr_ctrl", wr_ctrl, 1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_ctrl", {rd_ctrl, wr_ctrl, busy}, 0);
      check("async_rst_pulses", {ack, abort}, 0);
      check("async_rst_grant", grant_id, 0);
      check("async_rst_cnt_err", {pkt_cnt, timeout_err}, 0);
      step();
      check("rst_no_ack", {ack, abort}, 0);
      reset  = 1'b1;
      m_last = NCH - 1;
      m_cnt  = 0;
      m_err  = 1'b0;
      step();
      do_txn(4'b0001, 1, 1, 1'b0, 1'b0);

      // Single-channel instance, timeout disabled: long read phase never aborts
      enable1 = 1'b1;
      req1    = 1'b1;
      step();
      check("one_rd_ctrl", rd_ctrl1, 1);
      check("one_grant_id", grant_id1, 0);
      enable1 = 1'b0;
      req1    = 1'b0;
      repeat (20) step();
      check("one_rd_hold", rd_ctrl1, 1);
      check("one_no_abort", {abort1, timeout_err1}, 0);
      rd_rdy1 = 1'b1;
      step();
      rd_rdy1 = 1'b0;
      check("one_wr_ctrl", wr_ctrl1, 1);
      wr_rdy1 = 1'b1;
      step();
      wr_rdy1 = 1'b0;
      check("one_ack", ack1, 1);
      check("one_pkt_cnt", pkt_cnt1, 1);
      step();
      check("one_idle", busy1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_pkt_ctrl_mc
